execute_mem_stage: RTL and testbench
====================================

EXECUTE_MEM_STAGE -- requirements
Module: execute_mem_stage

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-002 The block SHALL have the following upstream ports, from the execute stage and ALU outputs:
- in_valid input 1: an instruction is presented.
- in_ready output 1: the block can accept an instruction.
- ResultE input 32: ALU result.
- ZeroE, NegativeE, OverFlowE, CarryE input 1 each: ALU flags.
- WriteDataE input 32: store data.
- RdE input 5: destination register.
- RegWriteE, MemReadE, MemWriteE, BranchE input 1 each: control bits.
- Funct3E input 3: branch condition.
- PCTargetE input 32: branch target.
REQ-003 The block SHALL have the following redirect ports:
- PCSrcE output 1: branch taken.
- PCTargetM output 32: registered branch target.
REQ-004 The block SHALL have the following data-memory ports:
- dmem_req output 1.
- dmem_we output 1.
- dmem_addr output 32.
- dmem_wdata output 32.
- dmem_ready input 1.
- dmem_rdata input 32.
REQ-005 The block SHALL have the following writeback ports:
- out_valid output 1.
- ResultW output 32.
- RdW output 5.
- RegWriteW output 1.
- mem_err output 1: sticky timeout flag.
REQ-006 The block SHALL have one parameter: TIMEOUT, default 16, the maximum number of dmem_ready wait cycles.

Function
REQ-007 The block SHALL use a three-state FSM with states IDLE, MEM_WAIT and DONE.
REQ-008 in_ready SHALL equal (state==IDLE), and an instruction SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-009 On acceptance, the block SHALL latch ResultE, WriteDataE, RdE, RegWriteE, MemReadE, MemWriteE and PCTargetE.
REQ-010 Branch condition on acceptance with BranchE=1, by Funct3E:
- 000: ZeroE.
- 001: !ZeroE.
- 100: NegativeE^OverFlowE.
- 101: !(NegativeE^OverFlowE).
- 110: !CarryE.
- 111: CarryE.
- 010 and 011: not taken.
REQ-011 PCSrcE SHALL be a registered one-cycle pulse in the cycle after acceptance when the branch is taken, with PCTargetM holding the latched target; PCSrcE SHALL be 0 otherwise.
REQ-012 Acceptance with MemReadE=0 and MemWriteE=0 SHALL move the FSM IDLE->DONE, with ResultW=ResultE.
REQ-013 Acceptance with MemReadE=1 or MemWriteE=1 SHALL move the FSM IDLE->MEM_WAIT.
- If both MemReadE and MemWriteE are 1, the access SHALL be treated as a store.
REQ-014 In MEM_WAIT, the block SHALL drive the memory request as follows:
- dmem_req=1.
- dmem_we=latched MemWrite.
- dmem_addr=latched result.
- dmem_wdata=latched write data.
- These values SHALL be held constant until dmem_ready.
REQ-015 In MEM_WAIT with dmem_ready=1, the FSM SHALL move to DONE.
- For a load, ResultW SHALL be dmem_rdata captured on that edge.
- For a store, ResultW SHALL be the address, and RegWriteW SHALL be forced to 0.
REQ-016 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with dmem_ready=0.
REQ-017 When the wait counter reaches TIMEOUT, the block SHALL do all of the following:
- Set mem_err=1.
- Move to DONE with ResultW=0 and RegWriteW=0.
REQ-018 In DONE, out_valid SHALL be 1 for exactly one cycle, RdW and RegWriteW SHALL be valid, and the next state SHALL be IDLE.
REQ-019 Outside DONE, out_valid SHALL be 0 and RegWriteW SHALL be 0.
REQ-020 Latency SHALL be as follows:
- Non-memory instruction: out_valid in the first cycle after the acceptance edge.
- Memory instruction: out_valid in the cycle after the edge that samples dmem_ready=1.
- Throughput: one instruction per 2 cycles minimum.
REQ-021 dmem_req SHALL be 0 in IDLE and in DONE.
REQ-022 in_valid presented while in_ready=0 SHALL be ignored; the upstream stage holds it.
REQ-023 dmem_ready asserted outside MEM_WAIT SHALL be ignored.
REQ-024 mem_err SHALL clear only on reset.

Reset
REQ-025 When rst=0, asynchronously and independent of clk, the block SHALL set the following reset state:
- state=IDLE.
- in_ready=1.
- All other outputs 0, including out_valid, PCSrcE, dmem_req, mem_err, ResultW, RdW and PCTargetM.
- Wait counter 0.
REQ-026 Reset asserted mid-MEM_WAIT SHALL drop dmem_req immediately, discard the pending instruction, and produce no out_valid after release.

Verification
REQ-027 ALU op: ResultE=0x0000_002A, RdE=5, RegWriteE=1 -> next cycle out_valid=1, ResultW=0x2A, RdW=5, RegWriteW=1; one cycle later in_ready=1.
REQ-028 Load with 3-cycle wait: ResultE=0x100, MemReadE=1, dmem_ready high in the 3rd MEM_WAIT cycle with dmem_rdata=0xDEAD_BEEF -> dmem_addr=0x100 held 3 cycles, then ResultW=0xDEADBEEF, out_valid pulse.
REQ-029 Store: MemWriteE=1, WriteDataE=0x1234, dmem_ready=1 immediately -> dmem_we=1, dmem_wdata=0x1234 for one cycle; out_valid=1 with RegWriteW=0.
REQ-030 Branches:
- BranchE=1, Funct3E=000, ZeroE=1 -> PCSrcE pulse, PCTargetM=PCTargetE.
- Funct3E=100, NegativeE=1, OverFlowE=1 -> PCSrcE=0.
- Funct3E=110, CarryE=0 -> PCSrcE pulse.
REQ-031 Timeout: load with dmem_ready held 0 -> after 16 wait cycles mem_err=1, out_valid=1 with RegWriteW=0; mem_err stays 1 across later instructions.
REQ-032 Reset mid-access: rst=0 during MEM_WAIT -> dmem_req=0 the same cycle without a clock edge; after release in_ready=1 and out_valid never pulses.

Source files
------------

// File: rtl/execute_mem_stage_if.sv
// rtl/execute_mem_stage_if.sv - data-memory request/response bus between the stage and memory
// Signals:
//   dmem_req   : access request, held until dmem_ready
//   dmem_we    : 1 = store, 0 = load
//   dmem_addr  : byte address of the access
//   dmem_wdata : store data
//   dmem_ready : memory completes the access on this edge
//   dmem_rdata : load data, valid with dmem_ready
interface execute_mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/execute_mem_stage.sv
// rtl/execute_mem_stage.sv - execute/memory stage: branch resolve, one data access, writeback
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake, accept when both high
//   ResultE .. PCTargetE  : ALU result, flags, store data, destination and control bits
//   PCSrcE / PCTargetM    : registered branch-taken pulse and latched branch target
//   dmem                  : data-memory bus (master side)
//   out_valid .. RegWriteW: one-cycle writeback pulse with result and destination
//   mem_err               : sticky flag, set when a memory access times out
module execute_mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 ResultE,
    input  logic                        ZeroE,
    input  logic                        NegativeE,
    input  logic                        OverFlowE,
    input  logic                        CarryE,
    input  logic [31:0]                 WriteDataE,
    input  logic [4:0]                  RdE,
    input  logic                        RegWriteE,
    input  logic                        MemReadE,
    input  logic                        MemWriteE,
    input  logic                        BranchE,
    input  logic [2:0]                  Funct3E,
    input  logic [31:0]                 PCTargetE,
    output logic                        PCSrcE,
    output logic [31:0]                 PCTargetM,
    execute_mem_stage_if.master         dmem,
    output logic                        out_valid,
    output logic [31:0]                 ResultW,
    output logic [4:0]                  RdW,
    output logic                        RegWriteW,
    output logic                        mem_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [4:0]    rd_q;
    logic          regwrite_q;
    logic          memread_q;
    logic          memwrite_q;
    logic [31:0]   target_q;
    logic          pcsrc_q;
    logic          out_valid_q;
    logic [31:0]   result_w_q;
    logic [4:0]    rd_w_q;
    logic          regwrite_w_q;
    logic          mem_err_q;
    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    logic          wait_expired;
    logic          branch_cond;
    logic          mem_is_load;

    always_comb begin
        branch_cond = 1'b0;
        case (Funct3E)
            3'b000:  branch_cond = ZeroE;
            3'b001:  branch_cond = ~ZeroE;
            3'b100:  branch_cond = NegativeE ^ OverFlowE;
            3'b101:  branch_cond = ~(NegativeE ^ OverFlowE);
            3'b110:  branch_cond = ~CarryE;
            3'b111:  branch_cond = CarryE;
            default: branch_cond = 1'b0;
        endcase
    end

    // The count that this idle MEM_WAIT cycle would reach; hitting TIMEOUT ends the access.
    assign wait_cnt_d   = wait_cnt_q + 1'b1;
    assign wait_expired = (wait_cnt_d == CW'(TIMEOUT));

    // Read and write both set is a store.
    assign mem_is_load  = memread_q & ~memwrite_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            target_q     <= '0;
            pcsrc_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            result_w_q   <= '0;
            rd_w_q       <= '0;
            regwrite_w_q <= 1'b0;
            mem_err_q    <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            // Pulses default low; they are raised only on the edge entering their cycle.
            pcsrc_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            regwrite_w_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        addr_q     <= ResultE;
                        wdata_q    <= WriteDataE;
                        rd_q       <= RdE;
                        regwrite_q <= RegWriteE;
                        memread_q  <= MemReadE;
                        memwrite_q <= MemWriteE;
                        target_q   <= PCTargetE;
                        pcsrc_q    <= BranchE & branch_cond;
                        if (MemReadE || MemWriteE) begin
                            state_q    <= MEM_WAIT;
                            wait_cnt_q <= '0;
                        end else begin
                            state_q      <= DONE;
                            out_valid_q  <= 1'b1;
                            result_w_q   <= ResultE;
                            rd_w_q       <= RdE;
                            regwrite_w_q <= RegWriteE;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (dmem.dmem_ready) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        rd_w_q      <= rd_q;
                        if (mem_is_load) begin
                            result_w_q   <= dmem.dmem_rdata;
                            regwrite_w_q <= regwrite_q;
                        end else begin
                            result_w_q   <= addr_q;
                            regwrite_w_q <= 1'b0;
                        end
                    end else if (wait_expired) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        mem_err_q   <= 1'b1;
                        result_w_q  <= '0;
                        rd_w_q      <= rd_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign PCSrcE          = pcsrc_q;
    assign PCTargetM       = target_q;
    // Request is a decode of the state register so reset removes it without a clock edge.
    assign dmem.dmem_req   = (state_q == MEM_WAIT);
    assign dmem.dmem_we    = (state_q == MEM_WAIT) & memwrite_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign out_valid       = out_valid_q;
    assign ResultW         = result_w_q;
    assign RdW             = rd_w_q;
    assign RegWriteW       = regwrite_w_q;
    assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_execute_mem_stage.sv
// tb/tb_execute_mem_stage.sv - self-checking bench for execute_mem_stage
module tb_execute_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ResultE;
    logic        ZeroE, NegativeE, OverFlowE, CarryE;
    logic [31:0] WriteDataE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemReadE, MemWriteE, BranchE;
    logic [2:0]  Funct3E;
    logic [31:0] PCTargetE;
    logic        PCSrcE;
    logic [31:0] PCTargetM;
    logic        out_valid;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic        mem_err;

    execute_mem_stage_if dmem_if ();

    execute_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ResultE    (ResultE),
        .ZeroE      (ZeroE),
        .NegativeE  (NegativeE),
        .OverFlowE  (OverFlowE),
        .CarryE     (CarryE),
        .WriteDataE (WriteDataE),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .MemReadE   (MemReadE),
        .MemWriteE  (MemWriteE),
        .BranchE    (BranchE),
        .Funct3E    (Funct3E),
        .PCTargetE  (PCTargetE),
        .PCSrcE     (PCSrcE),
        .PCTargetM  (PCTargetM),
        .dmem       (dmem_if),
        .out_valid  (out_valid),
        .ResultW    (ResultW),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit model_err    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic branch_rule(input logic [2:0] f3, input logic z, input logic n,
                                         input logic v, input logic c);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n ^ v;
            3'b101:  return !(n ^ v);
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    // One instruction end to end. w = MEM_WAIT cycle in which dmem_ready is raised;
    // w > TIMEOUT means memory never answers.
    task automatic run_instr(input logic [31:0] res, input logic [31:0] wd, input logic [31:0] tgt,
                             input logic [4:0] rd, input logic regw, input logic mr,
                             input logic mw, input logic br, input logic [2:0] f3,
                             input logic z, input logic n, input logic v, input logic c,
                             input int w, input logic [31:0] rdata);
        logic        taken;
        int          nwait;
        logic [31:0] exp_res;
        logic        exp_rw;

        taken = br && branch_rule(f3, z, n, v, c);
        check_eq("in_ready_idle", in_ready, 1'b1);
        ResultE    = res;  WriteDataE = wd;  PCTargetE = tgt;  RdE = rd;
        RegWriteE  = regw; MemReadE   = mr;  MemWriteE = mw;   BranchE = br;
        Funct3E    = f3;   ZeroE      = z;   NegativeE = n;    OverFlowE = v; CarryE = c;
        in_valid   = 1'b1;
        dmem_if.dmem_ready = 1'($urandom);
        dmem_if.dmem_rdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pcsrc", PCSrcE, taken);
        if (taken) check_eq("pctarget", PCTargetM, tgt);

        if (mr || mw) begin
            nwait = (w <= TIMEOUT) ? w : TIMEOUT;
            for (int i = 1; i <= nwait; i++) begin
                check_eq("dmem_req", dmem_if.dmem_req, 1'b1);
                check_eq("dmem_we", dmem_if.dmem_we, mw);
                check_eq("dmem_addr", dmem_if.dmem_addr, res);
                check_eq("dmem_wdata", dmem_if.dmem_wdata, wd);
                check_eq("busy_out_valid", out_valid, 1'b0);
                check_eq("busy_regwrite", RegWriteW, 1'b0);
                check_eq("busy_in_ready", in_ready, 1'b0);
                if (i > 1) check_eq("pcsrc_low", PCSrcE, 1'b0);
                dmem_if.dmem_ready = (i == w);
                dmem_if.dmem_rdata = (i == w) ? rdata : $urandom;
                // Upstream noise while busy must be ignored.
                in_valid = 1'($urandom);
                ResultE  = $urandom;
                @(posedge clk);
                @(negedge clk);
            end
            in_valid = 1'b0;
            dmem_if.dmem_ready = 1'($urandom);
            if (w > TIMEOUT) begin
                exp_res   = 32'h0;
                exp_rw    = 1'b0;
                model_err = 1'b1;
            end else if (mw) begin
                exp_res = res;
                exp_rw  = 1'b0;
            end else begin
                exp_res = rdata;
                exp_rw  = regw;
            end
        end else begin
            exp_res = res;
            exp_rw  = regw;
        end

        check_eq("out_valid", out_valid, 1'b1);
        check_eq("ResultW", ResultW, exp_res);
        check_eq("RdW", RdW, rd);
        check_eq("RegWriteW", RegWriteW, exp_rw);
        check_eq("mem_err", mem_err, model_err);
        check_eq("done_req", dmem_if.dmem_req, 1'b0);
        check_eq("done_in_ready", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_eq("post_out_valid", out_valid, 1'b0);
        check_eq("post_regwrite", RegWriteW, 1'b0);
        check_eq("post_in_ready", in_ready, 1'b1);
        check_eq("post_req", dmem_if.dmem_req, 1'b0);
        check_eq("post_pcsrc", PCSrcE, 1'b0);
        dmem_if.dmem_ready = 1'b0;
    endtask

    initial begin
        in_valid = 0; ResultE = 0; ZeroE = 0; NegativeE = 0; OverFlowE = 0; CarryE = 0;
        WriteDataE = 0; RdE = 0; RegWriteE = 0; MemReadE = 0; MemWriteE = 0; BranchE = 0;
        Funct3E = 0; PCTargetE = 0;
        dmem_if.dmem_ready = 0; dmem_if.dmem_rdata = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_pcsrc", PCSrcE, 1'b0);
        check_eq("rst_req", dmem_if.dmem_req, 1'b0);
        check_eq("rst_mem_err", mem_err, 1'b0);
        check_eq("rst_ResultW", ResultW, 32'h0);
        check_eq("rst_RdW", RdW, 5'd0);
        check_eq("rst_RegWriteW", RegWriteW, 1'b0);
        check_eq("rst_PCTargetM", PCTargetM, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ALU op, load with 3 waits, store with immediate ready, branches.
        run_instr(32'h2A, 0, 0, 5'd5, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
        run_instr(32'h100, 0, 0, 5'd7, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 3, 32'hDEAD_BEEF);
        run_instr(32'h200, 32'h1234, 0, 5'd9, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0, 1, 0);
        run_instr(32'h0, 0, 32'h8000_0040, 5'd0, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 1, 0);
        run_instr(32'h0, 0, 32'h8000_0080, 5'd0, 0, 0, 0, 1, 3'b100, 0, 1, 1, 0, 1, 0);
        run_instr(32'h0, 0, 32'h8000_00C0, 5'd0, 0, 0, 0, 1, 3'b110, 0, 0, 0, 0, 1, 0);
        // Read+write together behaves as a store.
        run_instr(32'h300, 32'h55AA, 0, 5'd3, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0, 2, 32'h1111_2222);
        // Timeout, then mem_err must remain set on following instructions.
        run_instr(32'h400, 0, 0, 5'd11, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0, TIMEOUT + 5, 0);
        run_instr(32'h77, 0, 0, 5'd12, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);

        for (int k = 0; k < 250; k++) begin
            logic mr_r, mw_r;
            int   w_r;
            mr_r = ($urandom_range(0, 2) == 0);
            mw_r = ($urandom_range(0, 2) == 0);
            w_r  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT + 2)
                                               : $urandom_range(1, 4);
            run_instr($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), mr_r, mw_r,
                      1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), w_r, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a memory access.
        check_eq("mid_in_ready", in_ready, 1'b1);
        ResultE = 32'h500; MemReadE = 1'b1; MemWriteE = 1'b0; BranchE = 1'b0;
        RegWriteE = 1'b1; RdE = 5'd4; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; MemReadE = 1'b0;
        check_eq("mid_req_before", dmem_if.dmem_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_req_async", dmem_if.dmem_req, 1'b0);
        check_eq("mid_in_ready_async", in_ready, 1'b1);
        check_eq("mid_mem_err_clr", mem_err, 1'b0);
        model_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dmem_if.dmem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("after_rst_out_valid", out_valid, 1'b0);
            check_eq("after_rst_in_ready", in_ready, 1'b1);
        end
        dmem_if.dmem_ready = 1'b0;
        run_instr(32'h99, 0, 0, 5'd6, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
